// File: rtl/cpu_jtag_dbg_pkg.sv
// Shared types and constants for the CPU virtual-JTAG debug host.
package cpu_jtag_dbg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UIR,
        ST_CDR,
        ST_SDR,
        ST_UDR,
        ST_RTI,
        ST_RESP
    } state_e;

    localparam logic [1:0] IR_OCIMEM    = 2'd0;
    localparam logic [1:0] IR_TRACEMEM  = 2'd1;
    localparam logic [1:0] IR_BREAK     = 2'd2;
    localparam logic [1:0] IR_TRACECTRL = 2'd3;

    localparam int DR_WIDTH_DEFAULT = 38;

endpackage

// File: rtl/cpu_jtag_tck_gen.sv
// JTAG clock generator: TCK_DIV clk cycles low, then TCK_DIV high, while run is held.
module cpu_jtag_tck_gen
    import cpu_jtag_dbg_pkg::*;
#(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic tck,
    output logic tck_rise,
    output logic tck_fall
);

    localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

    if (TCK_DIV < 1) begin : g_div_check
        $error("cpu_jtag_tck_gen: TCK_DIV must be >= 1");
    end

    logic [CW-1:0] cnt_reg;
    logic          phase_reg;
    logic          half_done;

    assign half_done = (cnt_reg == CW'(TCK_DIV - 1));
    // Pulses mark the clk edge at which tck changes; tck_fall also closes a full period.
    assign tck_rise  = run & ~phase_reg & half_done;
    assign tck_fall  = run &  phase_reg & half_done;
    assign tck       = phase_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg   <= '0;
            phase_reg <= 1'b0;
        end else if (!run) begin
            cnt_reg   <= '0;
            phase_reg <= 1'b0;
        end else if (half_done) begin
            cnt_reg   <= '0;
            phase_reg <= ~phase_reg;
        end else begin
            cnt_reg   <= cnt_reg + CW'(1);
        end
    end

endmodule

// File: rtl/cpu_jtag_debug_host.sv
// Initiator side of the CPU virtual-JTAG debug link: sequences UIR/CDR/SDR/UDR/RTI per command.
module cpu_jtag_debug_host
    import cpu_jtag_dbg_pkg::*;
#(
    parameter int DR_WIDTH = DR_WIDTH_DEFAULT,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    input  logic                cmd_skip_dr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                busy,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam int CNT_W = $clog2(DR_WIDTH + 1);

    state_e                state_reg, state_next;
    logic                  skip_reg;
    logic [DR_WIDTH-1:0]   sr_reg;
    logic [DR_WIDTH-2:0]   sr_shift;
    logic [CNT_W-1:0]      bit_cnt_reg;
    logic [DR_WIDTH-1:0]   rsp_dr_reg;
    logic [IR_WIDTH-1:0]   rsp_ir_reg;
    logic [IR_WIDTH-1:0]   ir_in_reg;
    logic                  tdi_reg;
    logic                  run, tck_rise, tck_fall, accept, last_bit;

    assign run      = (state_reg != ST_IDLE) && (state_reg != ST_RESP);
    assign accept   = cmd_valid && (state_reg == ST_IDLE);
    assign last_bit = (bit_cnt_reg == CNT_W'(DR_WIDTH - 1));

    cpu_jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .run      (run),
        .tck      (vji_tck),
        .tck_rise (tck_rise),
        .tck_fall (tck_fall)
    );

    for (genvar gi = 0; gi < DR_WIDTH - 1; gi++) begin : g_shift
        assign sr_shift[gi] = sr_reg[gi + 1];
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (cmd_valid) state_next = ST_UIR;
            ST_UIR:  if (tck_fall)  state_next = skip_reg ? ST_RTI : ST_CDR;
            ST_CDR:  if (tck_fall)  state_next = ST_SDR;
            ST_SDR:  if (tck_fall && last_bit) state_next = ST_UDR;
            ST_UDR:  if (tck_fall)  state_next = ST_RTI;
            ST_RTI:  if (tck_fall)  state_next = ST_RESP;
            ST_RESP: if (rsp_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            skip_reg    <= 1'b0;
            sr_reg      <= '0;
            bit_cnt_reg <= '0;
            rsp_dr_reg  <= '0;
            rsp_ir_reg  <= '0;
            ir_in_reg   <= '0;
            tdi_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                skip_reg    <= cmd_skip_dr;
                sr_reg      <= cmd_dr;
                bit_cnt_reg <= '0;
                rsp_dr_reg  <= '0;
                rsp_ir_reg  <= '0;
                ir_in_reg   <= cmd_ir;
            end
            if (state_reg == ST_UIR && tck_rise)
                rsp_ir_reg <= vji_ir_out;
            if (state_reg == ST_SDR && tck_rise)
                sr_reg <= {vji_tdo, sr_shift};
            // tdi is only updated on tck falls so the target always sees it settled at the rise.
            if (tck_fall) begin
                if (state_reg == ST_CDR) begin
                    tdi_reg <= sr_reg[0];
                end else if (state_reg == ST_SDR) begin
                    if (last_bit) begin
                        tdi_reg    <= 1'b0;
                        rsp_dr_reg <= sr_reg;
                    end else begin
                        tdi_reg     <= sr_reg[0];
                        bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign cmd_ready  = (state_reg == ST_IDLE);
    assign busy       = (state_reg != ST_IDLE);
    assign rsp_valid  = (state_reg == ST_RESP);
    assign rsp_dr     = rsp_dr_reg;
    assign rsp_ir_out = rsp_ir_reg;
    assign vji_ir_in  = ir_in_reg;
    assign vji_tdi    = tdi_reg;
    assign vji_uir    = (state_reg == ST_UIR);
    assign vji_cdr    = (state_reg == ST_CDR);
    assign vji_sdr    = (state_reg == ST_SDR);
    assign vji_udr    = (state_reg == ST_UDR);
    assign vji_rti    = (state_reg == ST_IDLE) || (state_reg == ST_RTI);

endmodule

// File: tb/tb_cpu_jtag_debug_host.sv
// Scoreboard bench for cpu_jtag_debug_host: TCK_DIV=2 instance plus a TCK_DIV=1 instance.
module tb_cpu_jtag_debug_host;

    localparam int W = 38;

    typedef struct {
        logic [W-1:0] dr;
        logic [1:0]   ir;
        int           lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n, cmd_valid, cmd_skip_dr, rsp_ready;
    logic [1:0]   cmd_ir, vji_ir_out;
    logic [W-1:0] cmd_dr;

    logic         cmd_ready, rsp_valid, busy, vji_tck, vji_tdi, vji_tdo;
    logic         vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;
    logic [W-1:0] rsp_dr;
    logic [1:0]   rsp_ir_out, vji_ir_in;

    logic         b_cmd_valid, b_rsp_ready, b_cmd_ready, b_rsp_valid, b_busy, b_tck, b_tdi, b_tdo;
    logic         b_uir, b_cdr, b_sdr, b_udr, b_rti;
    logic [W-1:0] b_rsp_dr;
    logic [1:0]   b_rsp_ir_out, b_ir_in;

    cpu_jtag_debug_host #(.DR_WIDTH(W), .IR_WIDTH(2), .TCK_DIV(2)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .cmd_skip_dr(cmd_skip_dr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dr(rsp_dr), .rsp_ir_out(rsp_ir_out),
        .busy(busy), .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
        .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
        .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_rti(vji_rti)
    );

    cpu_jtag_debug_host #(.DR_WIDTH(W), .IR_WIDTH(2), .TCK_DIV(1)) dut_div1 (
        .clk(clk), .reset_n(reset_n), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
        .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .cmd_skip_dr(cmd_skip_dr),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_dr(b_rsp_dr), .rsp_ir_out(b_rsp_ir_out),
        .busy(b_busy), .vji_tck(b_tck), .vji_tdi(b_tdi), .vji_tdo(b_tdo),
        .vji_ir_in(b_ir_in), .vji_ir_out(vji_ir_out),
        .vji_uir(b_uir), .vji_cdr(b_cdr), .vji_sdr(b_sdr), .vji_udr(b_udr), .vji_rti(b_rti)
    );

    // Target models: capture on CDR, shift LSB first on SDR, latch on UDR, all at tck rise.
    logic [W-1:0] t_pre = '0, t_sr = '0, t_udr = '0;
    logic [W-1:0] b_t_pre = '0, b_t_sr = '0, b_t_udr = '0;
    int uir_rises = 0, cdr_rises = 0, sdr_rises = 0, udr_rises = 0, b_sdr_rises = 0;

    assign vji_tdo = t_sr[0];
    assign b_tdo   = b_t_sr[0];

    always @(posedge vji_tck) begin
        if (vji_cdr) t_sr <= t_pre;
        if (vji_sdr) t_sr <= {vji_tdi, t_sr[W-1:1]};
        if (vji_udr) t_udr <= t_sr;
        uir_rises += int'(vji_uir);
        cdr_rises += int'(vji_cdr);
        sdr_rises += int'(vji_sdr);
        udr_rises += int'(vji_udr);
    end

    always @(posedge b_tck) begin
        if (b_cdr) b_t_sr <= b_t_pre;
        if (b_sdr) b_t_sr <= {b_tdi, b_t_sr[W-1:1]};
        if (b_udr) b_t_udr <= b_t_sr;
        b_sdr_rises += int'(b_sdr);
    end

    logic prev_tdi = 1'b0, b_prev_tdi = 1'b0;
    int   tdi_viol = 0, b_tdi_viol = 0;
    always @(negedge clk) begin
        if (vji_tck && vji_tdi !== prev_tdi) tdi_viol++;
        if (b_tck && b_tdi !== b_prev_tdi) b_tdi_viol++;
        prev_tdi   = vji_tdi;
        b_prev_tdi = b_tdi;
    end

    // Drive a command on the TCK_DIV=2 instance; returns at the negedge following the accept.
    task automatic start_cmd(input logic [1:0] ir, input logic [W-1:0] dr, input logic skip,
                             input logic [W-1:0] pre, input logic [1:0] irout);
        exp_t e;
        int   guard = 0;
        t_pre = pre; vji_ir_out = irout;
        cmd_ir = ir; cmd_dr = dr; cmd_skip_dr = skip; cmd_valid = 1'b1;
        while (!cmd_ready && guard < 100) begin @(negedge clk); guard++; end
        @(negedge clk);
        cmd_valid = 1'b0;
        uir_rises = 0; cdr_rises = 0; sdr_rises = 0; udr_rises = 0;
        e.dr  = skip ? '0 : pre;
        e.ir  = irout;
        e.lat = skip ? 8 : 168;
        exp_q.push_back(e);
    endtask

    task automatic wait_rsp(output logic [W-1:0] dr, output logic [1:0] ir, output int lat);
        lat = 0;
        while (!rsp_valid && lat < 400) begin @(negedge clk); lat++; end
        dr = rsp_dr;
        ir = rsp_ir_out;
        $display("txn ir_in=%0d rsp_dr=%h rsp_ir_out=%0d latency=%0d", vji_ir_in, dr, ir, lat);
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        int act = 0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({cmd_ready, vji_rti, vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, rsp_valid, busy} !== 10'b1100000000) begin
            n_err++;
            $display("FAIL reset_ctrl got %b want 1100000000",
                     {cmd_ready, vji_rti, vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, rsp_valid, busy});
        end
        n_cmp++;
        if ({rsp_dr, rsp_ir_out, vji_ir_in} !== '0) begin
            n_err++;
            $display("FAIL reset_data got dr=%h ir_out=%0d ir_in=%0d want 0", rsp_dr, rsp_ir_out, vji_ir_in);
        end
        n_cmp++;
        if ({b_cmd_ready, b_rti, b_tck, b_busy, b_rsp_valid} !== 5'b11000) begin
            n_err++;
            $display("FAIL reset_div1 got %b want 11000", {b_cmd_ready, b_rti, b_tck, b_busy, b_rsp_valid});
        end
        reset_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!cmd_ready || busy || vji_tck || vji_uir || vji_cdr || vji_sdr || vji_udr || !vji_rti) act++;
        end
        n_cmp++;
        if (act !== 0) begin
            n_err++;
            $display("FAIL idle_quiet got %0d active cycles want 0", act);
        end
    endtask

    task automatic test_ocimem();
        logic [W-1:0] dr; logic [1:0] ir; int lat; exp_t e;
        start_cmd(2'd0, 38'h2A_5555_AAAA, 1'b0, 38'h3F_0000_FFFF, 2'b01);
        wait_rsp(dr, ir, lat);
        e = exp_q.pop_front();
        n_cmp++; if (dr !== e.dr) begin n_err++; $display("FAIL ocimem_rsp_dr got %h want %h", dr, e.dr); end
        n_cmp++; if (ir !== e.ir) begin n_err++; $display("FAIL ocimem_rsp_ir got %0d want %0d", ir, e.ir); end
        n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL ocimem_latency got %0d want %0d", lat, e.lat); end
        n_cmp++;
        if (t_udr !== 38'h2A_5555_AAAA) begin
            n_err++; $display("FAIL ocimem_target_udr got %h want 2a5555aaaa", t_udr);
        end
        n_cmp++;
        if ({uir_rises, cdr_rises, sdr_rises, udr_rises} !== {32'd1, 32'd1, 32'd38, 32'd1}) begin
            n_err++;
            $display("FAIL ocimem_periods got uir=%0d cdr=%0d sdr=%0d udr=%0d want 1/1/38/1",
                     uir_rises, cdr_rises, sdr_rises, udr_rises);
        end
        finish_rsp();
    endtask

    task automatic test_skip_dr();
        logic [W-1:0] dr; logic [1:0] ir; int lat; exp_t e;
        start_cmd(2'd2, 38'h12_3456_789A, 1'b1, 38'h05_0505_0505, 2'b10);
        n_cmp++; if (vji_ir_in !== 2'd2) begin n_err++; $display("FAIL skip_ir_in got %0d want 2", vji_ir_in); end
        wait_rsp(dr, ir, lat);
        e = exp_q.pop_front();
        n_cmp++; if (dr !== e.dr) begin n_err++; $display("FAIL skip_rsp_dr got %h want %h", dr, e.dr); end
        n_cmp++; if (ir !== e.ir) begin n_err++; $display("FAIL skip_rsp_ir got %0d want %0d", ir, e.ir); end
        n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL skip_latency got %0d want %0d", lat, e.lat); end
        n_cmp++;
        if ({uir_rises, cdr_rises, sdr_rises, udr_rises} !== {32'd1, 32'd0, 32'd0, 32'd0}) begin
            n_err++;
            $display("FAIL skip_periods got uir=%0d cdr=%0d sdr=%0d udr=%0d want 1/0/0/0",
                     uir_rises, cdr_rises, sdr_rises, udr_rises);
        end
        finish_rsp();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] dr, held; logic [1:0] ir; int lat, bad; exp_t e;
        start_cmd(2'd3, 38'h15_0F0F_0F0F, 1'b0, 38'h0A_1234_5678, 2'b11);
        wait_rsp(dr, ir, lat);
        e = exp_q.pop_front();
        n_cmp++; if (dr !== e.dr) begin n_err++; $display("FAIL bp_rsp_dr got %h want %h", dr, e.dr); end
        n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL bp_latency got %0d want %0d", lat, e.lat); end
        held = rsp_dr; bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (!rsp_valid || rsp_dr !== held || vji_tck || cmd_ready || !busy) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL bp_hold got %0d unstable cycles want 0", bad); end
        t_pre = 38'h01_8000_0001; vji_ir_out = 2'b01;
        cmd_ir = 2'd1; cmd_dr = 38'h3F_FFFF_0000; cmd_skip_dr = 1'b0;
        cmd_valid = 1'b1; rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_cmp++;
        if ({cmd_ready, busy, rsp_valid} !== 3'b100) begin
            n_err++; $display("FAIL bp_handshake got %b want 100", {cmd_ready, busy, rsp_valid});
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        uir_rises = 0; cdr_rises = 0; sdr_rises = 0; udr_rises = 0;
        e.dr = 38'h01_8000_0001; e.ir = 2'b01; e.lat = 168;
        exp_q.push_back(e);
        n_cmp++;
        if ({busy, vji_ir_in} !== 3'b101) begin
            n_err++; $display("FAIL bp_next_accept got busy=%b ir_in=%0d want 1/1", busy, vji_ir_in);
        end
        wait_rsp(dr, ir, lat);
        e = exp_q.pop_front();
        n_cmp++; if (dr !== e.dr) begin n_err++; $display("FAIL b2b_rsp_dr got %h want %h", dr, e.dr); end
        n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL b2b_latency got %0d want %0d", lat, e.lat); end
        finish_rsp();
    endtask

    task automatic test_reset_midway();
        logic [W-1:0] dr; logic [1:0] ir; int lat, guard, seen; exp_t e;
        start_cmd(2'd0, 38'h11_2233_4455, 1'b0, 38'h22_AABB_CCDD, 2'b00);
        guard = 0;
        while (sdr_rises < 10 && guard < 500) begin @(negedge clk); guard++; end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({cmd_ready, vji_rti, vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, rsp_valid, busy} !== 10'b1100000000) begin
            n_err++;
            $display("FAIL midreset_ctrl got %b want 1100000000",
                     {cmd_ready, vji_rti, vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, rsp_valid, busy});
        end
        n_cmp++;
        if ({rsp_dr, rsp_ir_out, vji_ir_in} !== '0) begin
            n_err++; $display("FAIL midreset_data got dr=%h ir_out=%0d want 0", rsp_dr, rsp_ir_out);
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (200) begin @(negedge clk); if (rsp_valid) seen++; end
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL midreset_no_rsp got %0d want 0", seen); end
        start_cmd(2'd1, 38'h00_DEAD_BEEF, 1'b0, 38'h3C_C33C_C33C, 2'b10);
        wait_rsp(dr, ir, lat);
        e = exp_q.pop_front();
        n_cmp++; if (dr !== e.dr) begin n_err++; $display("FAIL after_reset_dr got %h want %h", dr, e.dr); end
        n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL after_reset_latency got %0d want %0d", lat, e.lat); end
        finish_rsp();
    endtask

    task automatic test_random();
        logic [W-1:0] dr, cd, pre; logic [1:0] ir; int lat; exp_t e;
        for (int k = 0; k < 3; k++) begin
            cd  = {6'($urandom), $urandom};
            pre = {6'($urandom), $urandom};
            start_cmd(2'($urandom), cd, 1'b0, pre, 2'($urandom));
            wait_rsp(dr, ir, lat);
            e = exp_q.pop_front();
            n_cmp++; if (dr !== e.dr) begin n_err++; $display("FAIL rand%0d_rsp_dr got %h want %h", k, dr, e.dr); end
            n_cmp++; if (ir !== e.ir) begin n_err++; $display("FAIL rand%0d_rsp_ir got %0d want %0d", k, ir, e.ir); end
            n_cmp++; if (t_udr !== cd) begin n_err++; $display("FAIL rand%0d_target_udr got %h want %h", k, t_udr, cd); end
            finish_rsp();
        end
    endtask

    task automatic test_tck_div1();
        int guard = 0, lat = 0; exp_t e;
        b_t_pre = 38'h3F_0000_FFFF; vji_ir_out = 2'b00;
        cmd_ir = 2'd0; cmd_dr = 38'h2A_5555_AAAA; cmd_skip_dr = 1'b0; b_cmd_valid = 1'b1;
        while (!b_cmd_ready && guard < 100) begin @(negedge clk); guard++; end
        @(negedge clk);
        b_cmd_valid = 1'b0;
        b_sdr_rises = 0;
        e.dr = 38'h3F_0000_FFFF; e.ir = 2'b00; e.lat = 84;
        exp_q.push_back(e);
        while (!b_rsp_valid && lat < 400) begin @(negedge clk); lat++; end
        $display("txn div1 ir_in=%0d rsp_dr=%h latency=%0d", b_ir_in, b_rsp_dr, lat);
        e = exp_q.pop_front();
        n_cmp++; if (b_rsp_dr !== e.dr) begin n_err++; $display("FAIL div1_rsp_dr got %h want %h", b_rsp_dr, e.dr); end
        n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL div1_latency got %0d want %0d", lat, e.lat); end
        n_cmp++; if (b_t_udr !== 38'h2A_5555_AAAA) begin n_err++; $display("FAIL div1_target_udr got %h want 2a5555aaaa", b_t_udr); end
        n_cmp++; if (b_sdr_rises !== 38) begin n_err++; $display("FAIL div1_sdr_bits got %0d want 38", b_sdr_rises); end
        n_cmp++; if (b_tdi_viol !== 0) begin n_err++; $display("FAIL div1_tdi_while_tck_high got %0d want 0", b_tdi_viol); end
        n_cmp++; if (tdi_viol !== 0) begin n_err++; $display("FAIL div2_tdi_while_tck_high got %0d want 0", tdi_viol); end
        b_rsp_ready = 1'b1;
        @(negedge clk);
        b_rsp_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0; cmd_skip_dr = 1'b0;
        cmd_ir = '0; cmd_dr = '0; vji_ir_out = '0;
        b_cmd_valid = 1'b0; b_rsp_ready = 1'b0;
        test_reset();
        test_ocimem();
        test_skip_dr();
        test_backpressure();
        test_reset_midway();
        test_random();
        test_tck_div1();
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
